// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and sign helpers for the EX-stage multiply/divide sequencer.
// The optional single-cycle multiplier is selected by defining MULDIV_FAST_MUL_EN.
package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;
    localparam int CNT_W  = 6;

    localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] neg_op(input logic [DATA_W-1:0] v);
        neg_op = (~v) + 32'd1;
    endfunction

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v,
                                                 input logic              is_signed);
        if (is_signed && v[DATA_W-1]) begin
            abs_op = neg_op(v);
        end else begin
            abs_op = v;
        end
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration: shift-add multiply step or restoring divide step
// on the shared {upper, lower} accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic                  i_div,
    input  logic [2*DATA_W-1:0]   i_acc,
    input  logic [DATA_W-1:0]     i_opnd,
    output logic [2*DATA_W-1:0]   o_acc
);

    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W:0]   w_shl;
    logic [DATA_W:0]     w_top;
    logic [DATA_W-1:0]   w_diff;

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    // Divide: shift left, trial-subtract the divisor from the 33-bit partial remainder, restore on borrow.
    always_comb begin
        w_sum  = {1'b0, i_acc[2*DATA_W-1:DATA_W]} +
                 (i_acc[0] ? {1'b0, i_opnd} : {(DATA_W+1){1'b0}});
        w_shl  = {i_acc, 1'b0};
        w_top  = w_shl[2*DATA_W:DATA_W];
        w_diff = w_top[DATA_W-1:0] - i_opnd;
        if (i_div) begin
            if (w_top >= {1'b0, i_opnd}) begin
                o_acc = {w_diff, w_shl[DATA_W-1:1], 1'b1};
            end else begin
                o_acc = w_shl[2*DATA_W-1:0];
            end
        end else begin
            o_acc = {w_sum, i_acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; stalls the pipe while busy.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single RUN cycle.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              multiply,
    input  logic              div,
    input  logic              unsign,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_opnd;
    logic                  r_is_div;
    logic                  r_neg_lo;
    logic                  r_neg_hi;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_done;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_is_div_op;
    logic                  w_div0;
    logic                  w_signed;
    logic [DATA_W-1:0]     w_abs_a;
    logic [DATA_W-1:0]     w_abs_b;
    logic [2*DATA_W-1:0]   w_step_acc;
    logic [2*DATA_W-1:0]   w_run_acc;
    logic                  w_fast;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_fix_hi;
    logic [DATA_W-1:0]     w_fix_lo;

    assign w_req       = start & (multiply | div);
    assign w_accept    = (r_state == ST_IDLE) & w_req & ~cancel;
    assign w_is_div_op = div & ~multiply;
    assign w_div0      = w_is_div_op & (src_b == 32'd0);
    assign w_signed    = ~unsign;
    assign w_abs_a     = abs_op(src_a, w_signed);
    assign w_abs_b     = abs_op(src_b, w_signed);

    assign stall  = ((r_state == ST_IDLE) & w_req) | (r_state != ST_IDLE);
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

    muldiv_step u_step (
        .i_div  (r_is_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc)
    );

`ifdef MULDIV_FAST_MUL_EN
    assign w_fast    = ~r_is_div;
    assign w_run_acc = r_is_div ? w_step_acc
                                : ({32'd0, r_acc[DATA_W-1:0]} * {32'd0, r_opnd});
`else
    assign w_fast    = 1'b0;
    assign w_run_acc = w_step_acc;
`endif

    // Sign correction applied in FIX; divide-by-zero results are loaded raw with both flags clear.
    always_comb begin
        w_prod = (~r_acc) + 64'd1;
        if (r_is_div) begin
            w_fix_lo = r_neg_lo ? neg_op(r_acc[DATA_W-1:0])        : r_acc[DATA_W-1:0];
            w_fix_hi = r_neg_hi ? neg_op(r_acc[2*DATA_W-1:DATA_W]) : r_acc[2*DATA_W-1:DATA_W];
        end else if (r_neg_lo) begin
            w_fix_lo = w_prod[DATA_W-1:0];
            w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
        end else begin
            w_fix_lo = r_acc[DATA_W-1:0];
            w_fix_hi = r_acc[2*DATA_W-1:DATA_W];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div0 ? ST_FIX : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fast || (r_cnt == CNT_W'(ITER - 1))) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath, HI/LO writeback and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= {CNT_W{1'b0}};
                        r_is_div <= w_is_div_op;
                        r_opnd   <= w_abs_b;
                        if (w_div0) begin
                            r_acc    <= {src_a, DIV0_LO};
                            r_neg_lo <= 1'b0;
                            r_neg_hi <= 1'b0;
                        end else begin
                            r_acc    <= {32'd0, w_abs_a};
                            r_neg_lo <= w_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                            r_neg_hi <= w_signed & src_a[DATA_W-1];
                        end
                    end else begin
                        if (hi_we) begin
                            r_hi <= wdata;
                        end
                        if (lo_we) begin
                            r_lo <= wdata;
                        end
                    end
                end
                ST_RUN: begin
                    if (!cancel) begin
                        r_acc <= w_run_acc;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_FIX: begin
                    if (!cancel) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; follows MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, multiply, div, unsign, cancel, hi_we, lo_we;
    logic [31:0] src_a, src_b, wdata;
    logic        stall, busy, done;
    logic [31:0] hi_out, lo_out;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_DONE = 3;
`else
    localparam int MUL_DONE = 34;
`endif

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .multiply(multiply), .div(div),
        .unsign(unsign), .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .stall(stall), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the start cycle; returns after checking the done cycle and the cycle after it.
    task automatic do_op(input string tag, input logic m, input logic d, input logic u,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int edone);
        int  done_c;
        bit  seen;
        bit  stall_bad;
        start = 1'b1; multiply = m; div = d; unsign = u; src_a = a; src_b = b;
        #1;
        chk({tag, " stall c0"}, {31'd0, stall}, 32'd1);
        seen = 1'b0; stall_bad = 1'b0; done_c = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!seen) begin
                tick();
                start = 1'b0; multiply = 1'b0; div = 1'b0;
                #1;
                if (done) begin
                    seen = 1'b1;
                    done_c = c;
                end else if (!stall) begin
                    stall_bad = 1'b1;
                end
            end
        end
        chk({tag, " done seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " done cycle"}, done_c, edone);
        chk({tag, " stall while busy"}, {31'd0, stall_bad}, 32'd0);
        chk({tag, " stall at done"}, {31'd0, stall}, 32'd0);
        chk({tag, " hi"}, hi_out, ehi);
        chk({tag, " lo"}, lo_out, elo);
        tick();
        #1;
        chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        reset = 1'b1; start = 1'b0; multiply = 1'b0; div = 1'b0; unsign = 1'b0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
        tick(); tick();
        chk("reset hi", hi_out, 32'd0);
        chk("reset lo", lo_out, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();

        do_op("MULT",  1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_DONE);
        do_op("MULTU", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL_DONE);
        do_op("DIVU",  1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        do_op("DIV",   1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        do_op("DIVOVF", 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
        do_op("DIV0",  1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2);
        do_op("MULTUS", 1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'd0, MUL_DONE);

        // start without an operation qualifier is ignored
        start = 1'b1; src_a = 32'd9; src_b = 32'd9;
        #1;
        chk("nop stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        #1;
        chk("nop busy", {31'd0, busy}, 32'd0);

        // MT writes, then a cancelled DIVU
        hi_we = 1'b1; wdata = 32'h11;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        tick();
        lo_we = 1'b0;
        #1;
        chk("mthi", hi_out, 32'h11);
        chk("mtlo", lo_out, 32'h22);
        start = 1'b1; div = 1'b1; unsign = 1'b1; src_a = 32'd100; src_b = 32'd7;
        done_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0; div = 1'b0;
            if (done) done_cnt++;
        end
        cancel = 1'b1;
        #1;
        chk("cancel busy c10", {31'd0, busy}, 32'd1);
        tick();
        cancel = 1'b0;
        #1;
        chk("cancel busy c11", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 30; c++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("cancel no done", done_cnt, 32'd0);
        chk("cancel hi", hi_out, 32'h11);
        chk("cancel lo", lo_out, 32'h22);

        // MTHI in IDLE
        hi_we = 1'b1; wdata = 32'h1234;
        tick();
        hi_we = 1'b0;
        #1;
        chk("mthi idle", hi_out, 32'h1234);
        chk("mthi lo kept", lo_out, 32'h22);

        // hi_we during RUN is ignored; async reset mid-divide
        start = 1'b1; div = 1'b1; unsign = 1'b1; src_a = 32'd100; src_b = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0; div = 1'b0;
        end
        hi_we = 1'b1; wdata = 32'hDEAD;
        tick();
        hi_we = 1'b0;
        #1;
        chk("mthi run ignored", hi_out, 32'h1234);
        for (int c = 7; c <= 15; c++) begin
            tick();
        end
        reset = 1'b1;
        #1;
        chk("areset hi", hi_out, 32'd0);
        chk("areset lo", lo_out, 32'd0);
        chk("areset busy", {31'd0, busy}, 32'd0);
        chk("areset stall", {31'd0, stall}, 32'd0);
        chk("areset done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        do_op("post reset MULTU", 1'b1, 1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, MUL_DONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
